// File: rtl/ifetch_pkg.sv
// Shared types, constants and the opcode length decode for the instruction fetch unit.
package ifetch_pkg;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam int          EXT_BIT  = 7;

  typedef enum logic [2:0] {
    ST_OP   = 3'd0,
    ST_B1   = 3'd1,
    ST_B2   = 3'd2,
    ST_B3   = 3'd3,
    ST_HOLD = 3'd4
  } fetch_state_e;

  typedef struct packed {
    logic [7:0]  byte0;
    logic [7:0]  byte1;
    logic [7:0]  byte2;
    logic [7:0]  ext;
    logic [2:0]  len;
    logic [15:0] pc;
  } instr_t;

  localparam instr_t INSTR_RESET = '{byte0: 8'h00, byte1: 8'h00, byte2: 8'h00,
                                     ext: 8'h00, len: 3'd1, pc: RESET_PC};

  function automatic logic [2:0] instr_length(input logic [7:0] op);
    logic [2:0] len;
    if (op == 8'h00) begin
      len = 3'd1;
    end else if (op[EXT_BIT]) begin
      len = 3'd4;
    end else if (op[1:0] != 2'b00) begin
      len = 3'd3;
    end else begin
      len = 3'd2;
    end
    return len;
  endfunction

endpackage

// File: rtl/instr_skid.sv
// One-entry holding register for a fully assembled instruction.
module instr_skid
  import ifetch_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   load,
  input  logic   pop,
  input  instr_t din,
  output logic   valid,
  output instr_t dout
);

  logic   valid_r;
  instr_t data_r;

  // Entry capture and release; load wins because it never coincides with pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_r <= 1'b0;
      data_r  <= INSTR_RESET;
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= din;
    end else if (pop) begin
      valid_r <= 1'b0;
    end
  end

  assign valid = valid_r;
  assign dout  = data_r;

endmodule

// File: rtl/instr_fetch.sv
// Byte-serial instruction fetch and assembly in front of the decoder.
// Optional feature: IFETCH_SKID_EN adds a holding register so fetch runs ahead of the decoder.
module instr_fetch
  import ifetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic        mem_valid,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  instr_byte0,
  output logic [7:0]  instr_byte1,
  output logic [7:0]  instr_byte2,
  output logic [7:0]  ext_instr_byte,
  output logic [2:0]  instr_len,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc
);

  fetch_state_e state_r, state_next_s;
  logic [15:0]  pc_r;
  logic         mem_rd_r, mem_rd_next_s;
  logic         instr_valid_r;
  instr_t       asm_r, new_instr_s, out_r, skid_q_s;
  logic         done_s, final_s, transfer_s;
  logic         skid_valid_s, skid_load_s, skid_pop_s, skid_valid_next_s;

`ifdef IFETCH_SKID_EN
  localparam fetch_state_e FINAL_STATE = ST_OP;
  assign skid_load_s = final_s & instr_valid_r & ~transfer_s;
`else
  localparam fetch_state_e FINAL_STATE = ST_HOLD;
  assign skid_load_s = 1'b0;
`endif

  assign done_s            = mem_rd_r & mem_valid;
  assign transfer_s        = instr_valid_r & instr_ready;
  assign skid_pop_s        = transfer_s & skid_valid_s;
  assign skid_valid_next_s = ~redirect_valid & (skid_load_s | (skid_valid_s & ~skid_pop_s));
  assign mem_rd_next_s     = (state_next_s != ST_HOLD) & ~skid_valid_next_s;

  // Merge the byte returned this cycle into the partially assembled instruction.
  always_comb begin
    new_instr_s = asm_r;
    case (state_r)
      ST_OP: begin
        new_instr_s.byte0 = mem_rdata;
        new_instr_s.byte1 = 8'h00;
        new_instr_s.byte2 = 8'h00;
        new_instr_s.ext   = 8'h00;
        new_instr_s.len   = instr_length(mem_rdata);
        new_instr_s.pc    = pc_r;
      end
      ST_B1:   new_instr_s.byte1 = mem_rdata;
      ST_B2:   new_instr_s.byte2 = mem_rdata;
      ST_B3:   new_instr_s.ext   = mem_rdata;
      default: new_instr_s       = asm_r;
    endcase
  end

  // Flag the completion that finishes the current instruction.
  always_comb begin
    case (state_r)
      ST_OP:   final_s = done_s & (new_instr_s.len == 3'd1);
      ST_B1:   final_s = done_s & (new_instr_s.len == 3'd2);
      ST_B2:   final_s = done_s & (new_instr_s.len == 3'd3);
      ST_B3:   final_s = done_s;
      default: final_s = 1'b0;
    endcase
  end

  // Next-state decode; a redirect always restarts at the opcode fetch.
  always_comb begin
    state_next_s = state_r;
    if (redirect_valid) begin
      state_next_s = ST_OP;
    end else begin
      case (state_r)
        ST_OP:   state_next_s = done_s ? (final_s ? FINAL_STATE : ST_B1) : ST_OP;
        ST_B1:   state_next_s = done_s ? (final_s ? FINAL_STATE : ST_B2) : ST_B1;
        ST_B2:   state_next_s = done_s ? (final_s ? FINAL_STATE : ST_B3) : ST_B2;
        ST_B3:   state_next_s = done_s ? FINAL_STATE : ST_B3;
        ST_HOLD: state_next_s = transfer_s ? ST_OP : ST_HOLD;
        default: state_next_s = ST_OP;
      endcase
    end
  end

  // FSM, fetch pointer, read request and assembly registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_OP;
      pc_r     <= RESET_PC;
      mem_rd_r <= 1'b0;
      asm_r    <= INSTR_RESET;
    end else if (redirect_valid) begin
      state_r  <= ST_OP;
      pc_r     <= redirect_pc;
      mem_rd_r <= 1'b1;
      asm_r    <= INSTR_RESET;
    end else begin
      state_r  <= state_next_s;
      mem_rd_r <= mem_rd_next_s;
      if (done_s) begin
        pc_r  <= pc_r + 16'd1;
        asm_r <= new_instr_s;
      end
    end
  end

  // Output stage: the holding register drains ahead of a freshly assembled instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r         <= INSTR_RESET;
      instr_valid_r <= 1'b0;
    end else if (redirect_valid) begin
      instr_valid_r <= 1'b0;
    end else if (transfer_s) begin
      if (skid_valid_s) begin
        out_r         <= skid_q_s;
        instr_valid_r <= 1'b1;
      end else if (final_s) begin
        out_r         <= new_instr_s;
        instr_valid_r <= 1'b1;
      end else begin
        instr_valid_r <= 1'b0;
      end
    end else if (final_s && !instr_valid_r) begin
      out_r         <= new_instr_s;
      instr_valid_r <= 1'b1;
    end
  end

  instr_skid u_skid (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .load  (skid_load_s),
    .pop   (skid_pop_s),
    .din   (new_instr_s),
    .valid (skid_valid_s),
    .dout  (skid_q_s)
  );

  assign mem_rd         = mem_rd_r;
  assign mem_addr       = pc_r;
  assign instr_byte0    = out_r.byte0;
  assign instr_byte1    = out_r.byte1;
  assign instr_byte2    = out_r.byte2;
  assign ext_instr_byte = out_r.ext;
  assign instr_len      = out_r.len;
  assign instr_pc       = out_r.pc;
  assign instr_valid    = instr_valid_r;

endmodule
